// File: rtl/add1_pkg.sv
// Shared constants, counter sizing and flag layout for the add1 bit-serial adder slice.
package add1_pkg;

    localparam int ADD1_DEFAULT_WIDTH = 64;

    function automatic int add1CntWidth(input int width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

    typedef struct packed {
        logic c;
        logic o;
        logic z;
    } add1_flags_t;

endpackage

// File: rtl/full_adder_cell.sv
// Purely combinational one-bit full adder used as the arithmetic core of add1_core.
module full_adder_cell (
    input  logic a_i,
    input  logic b_i,
    input  logic ci_i,
    output logic s_o,
    output logic co_o
);

    assign s_o  = a_i ^ b_i ^ ci_i;
    assign co_o = (a_i & b_i) | (a_i & ci_i) | (b_i & ci_i);

endmodule

// File: rtl/add1_core.sv
// Registered 1-bit full adder / bit-serial adder with end-of-word C/O/Z flags.
// Optional subtract mode is enabled by defining ADD1_SUB_EN.
module add1_core
    import add1_pkg::*;
#(
    parameter int WIDTH  = ADD1_DEFAULT_WIDTH,
    parameter int SERIAL = 1
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             in_valid,
    input  logic                             a,
    input  logic                             b,
    input  logic                             cin,
`ifdef ADD1_SUB_EN
    input  logic                             sub,
`endif
    input  logic                             sof,
    input  logic                             eof,
    output logic                             sum,
    output logic                             co,
    output logic                             out_valid,
    output logic                             word_done,
    output logic                             flag_c,
    output logic                             flag_o,
    output logic                             flag_z,
    output logic [add1CntWidth(WIDTH)-1:0]   bit_idx
);

    localparam int CNT_W = add1CntWidth(WIDTH);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

    logic             carry_q;
    logic             zacc_q;
    logic             zacc_d;
    logic [CNT_W-1:0] bitCnt_q;
    logic [CNT_W-1:0] bitCnt_d;
    logic [CNT_W-1:0] curIdx;
    add1_flags_t      flags_q;
    add1_flags_t      flags_d;

    logic subEff;
    logic bEff;
    logic cEff;
    logic sBit;
    logic cBit;
    logic isStart;
    logic lastBit;

`ifdef ADD1_SUB_EN
    logic sub_q;

    // Subtract mode is latched at the first bit and applies to the whole word.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sub_q <= 1'b0;
        end else if (in_valid && sof) begin
            sub_q <= sub;
        end
    end

    assign subEff = sof ? sub : sub_q;
`else
    assign subEff = 1'b0;
`endif

    assign bEff = b ^ subEff;

    full_adder_cell u_fa (
        .a_i  (a),
        .b_i  (bEff),
        .ci_i (cEff),
        .s_o  (sBit),
        .co_o (cBit)
    );

    // An idle counter with no sof still starts a word, but keeps carry_q as carry-in.
    always_comb begin
        cEff = carry_q;
        if (sof || (SERIAL == 0)) begin
            cEff = (sof && subEff) ? 1'b1 : cin;
        end

        curIdx  = sof ? '0 : bitCnt_q;
        isStart = (curIdx == '0);
        lastBit = eof || (curIdx == LAST_IDX);

        zacc_d   = isStart ? sBit : (zacc_q | sBit);
        bitCnt_d = lastBit ? '0 : (curIdx + 1'b1);

        flags_d.c = cBit;
        flags_d.o = cEff ^ cBit;
        flags_d.z = ~zacc_d;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sum       <= 1'b0;
            co        <= 1'b0;
            out_valid <= 1'b0;
            word_done <= 1'b0;
            carry_q   <= 1'b0;
            zacc_q    <= 1'b0;
            bitCnt_q  <= '0;
            bit_idx   <= '0;
            flags_q   <= '{c: 1'b0, o: 1'b0, z: 1'b1};
        end else if (in_valid) begin
            sum       <= sBit;
            co        <= cBit;
            out_valid <= 1'b1;
            carry_q   <= cBit;
            zacc_q    <= zacc_d;
            bitCnt_q  <= bitCnt_d;
            bit_idx   <= curIdx;
            word_done <= lastBit;
            if (lastBit) begin
                flags_q <= flags_d;
            end
        end else begin
            out_valid <= 1'b0;
            word_done <= 1'b0;
        end
    end

    assign flag_c = flags_q.c;
    assign flag_o = flags_q.o;
    assign flag_z = flags_q.z;

endmodule

// File: tb/tb_add1_core.sv
// Directed self-checking bench for add1_core: a WIDTH=4 serial instance and a WIDTH=4 SERIAL=0 instance.
module tb_add1_core;

    logic clk = 1'b0;
    logic rst_n;
    logic in_valid;
    logic a;
    logic b;
    logic cin;
    logic sof;
    logic eof;
`ifdef ADD1_SUB_EN
    logic sub;
`endif

    logic       sSum, sCo, sOv, sWd, sFc, sFo, sFz;
    logic [1:0] sIdx;
    logic       pSum, pCo, pOv, pWd, pFc, pFo, pFz;
    logic [1:0] pIdx;

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    add1_core #(.WIDTH(4), .SERIAL(1)) dutSerial (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .cin       (cin),
`ifdef ADD1_SUB_EN
        .sub       (sub),
`endif
        .sof       (sof),
        .eof       (eof),
        .sum       (sSum),
        .co        (sCo),
        .out_valid (sOv),
        .word_done (sWd),
        .flag_c    (sFc),
        .flag_o    (sFo),
        .flag_z    (sFz),
        .bit_idx   (sIdx)
    );

    add1_core #(.WIDTH(4), .SERIAL(0)) dutPar (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .cin       (cin),
`ifdef ADD1_SUB_EN
        .sub       (sub),
`endif
        .sof       (sof),
        .eof       (eof),
        .sum       (pSum),
        .co        (pCo),
        .out_valid (pOv),
        .word_done (pWd),
        .flag_c    (pFc),
        .flag_o    (pFo),
        .flag_z    (pFz),
        .bit_idx   (pIdx)
    );

    task automatic checkOutput(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic va, input logic vb,
                                 input logic vc, input logic vs, input logic ve);
        @(negedge clk);
        in_valid = v;
        a        = va;
        b        = vb;
        cin      = vc;
        sof      = vs;
        eof      = ve;
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        @(negedge clk);
        rst_n    = 1'b0;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic checkIdle(input string tag);
        checkOutput({tag, "_sum"}, {3'b0, sSum}, 4'h0);
        checkOutput({tag, "_co"},  {3'b0, sCo},  4'h0);
        checkOutput({tag, "_ov"},  {3'b0, sOv},  4'h0);
        checkOutput({tag, "_wd"},  {3'b0, sWd},  4'h0);
        checkOutput({tag, "_fc"},  {3'b0, sFc},  4'h0);
        checkOutput({tag, "_fo"},  {3'b0, sFo},  4'h0);
        checkOutput({tag, "_fz"},  {3'b0, sFz},  4'h1);
        checkOutput({tag, "_idx"}, {2'b0, sIdx}, 4'h0);
    endtask

    task automatic runWord(input string tag, input logic [3:0] av, input logic [3:0] bv,
                           input logic ci, input logic [3:0] expSum, input logic expC,
                           input logic expO, input logic expZ, input bit gaps);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, av[i], bv[i], (i == 0) ? ci : 1'b0, i == 0, 1'b0);
            checkOutput($sformatf("%s_sum%0d", tag, i), {3'b0, sSum}, {3'b0, expSum[i]});
            checkOutput($sformatf("%s_idx%0d", tag, i), {2'b0, sIdx}, 4'(i));
            checkOutput($sformatf("%s_wd%0d", tag, i), {3'b0, sWd}, {3'b0, i == 3});
            if (gaps && i < 3) begin
                applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
                checkOutput($sformatf("%s_gapov%0d", tag, i), {3'b0, sOv}, 4'h0);
                checkOutput($sformatf("%s_gapsum%0d", tag, i), {3'b0, sSum}, {3'b0, expSum[i]});
            end
        end
        checkOutput({tag, "_fc"}, {3'b0, sFc}, {3'b0, expC});
        checkOutput({tag, "_fo"}, {3'b0, sFo}, {3'b0, expO});
        checkOutput({tag, "_fz"}, {3'b0, sFz}, {3'b0, expZ});
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput({tag, "_wdoff"}, {3'b0, sWd}, 4'h0);
        checkOutput({tag, "_fchold"}, {3'b0, sFc}, {3'b0, expC});
    endtask

    initial begin
        rst_n    = 1'b1;
        in_valid = 1'b0;
        a        = 1'b0;
        b        = 1'b0;
        cin      = 1'b0;
        sof      = 1'b0;
        eof      = 1'b0;
`ifdef ADD1_SUB_EN
        sub      = 1'b0;
`endif

        doReset();
        checkIdle("reset");

        // Plain registered full adder: cin is used on every bit.
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("par100", {2'b0, pSum, pCo}, 4'b0010);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("par110", {2'b0, pSum, pCo}, 4'b0001);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("par101", {2'b0, pSum, pCo}, 4'b0001);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("par000", {2'b0, pSum, pCo}, 4'b0000);
        checkOutput("parov",  {3'b0, pOv}, 4'h1);

        doReset();
        runWord("add5p3",  4'd5,  4'd3, 1'b0, 4'b1000, 1'b0, 1'b1, 1'b0, 1'b0);
        runWord("add0p0",  4'd0,  4'd0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0);
        runWord("add15p1", 4'd15, 4'd1, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b1, 1'b0);
        runWord("gap5p3",  4'd5,  4'd3, 1'b0, 4'b1000, 1'b0, 1'b1, 1'b0, 1'b1);

        // Abandon a word after three bits; reset must discard it.
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        doReset();
        checkIdle("midreset");
        runWord("afterrst", 4'd5, 4'd3, 1'b0, 4'b1000, 1'b0, 1'b1, 1'b0, 1'b0);

        // Single-bit word: sof and eof together.
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        checkOutput("onebit_sc",  {2'b0, sSum, sCo}, 4'b0011);
        checkOutput("onebit_wd",  {3'b0, sWd}, 4'h1);
        checkOutput("onebit_idx", {2'b0, sIdx}, 4'h0);
        checkOutput("onebit_flg", {1'b0, sFc, sFo, sFz}, 4'b0100);

        // Early eof on the second bit ends a two-bit word.
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("eof2_wd0", {3'b0, sWd}, 4'h0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("eof2_wd1", {3'b0, sWd}, 4'h1);
        checkOutput("eof2_idx", {2'b0, sIdx}, 4'h1);
        checkOutput("eof2_flg", {1'b0, sFc, sFo, sFz}, 4'b0000);

`ifdef ADD1_SUB_EN
        sub = 1'b1;
        runWord("sub3m5", 4'd3, 4'd5, 1'b0, 4'b1110, 1'b0, 1'b0, 1'b0, 1'b0);
        sub = 1'b0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
